exec_stage_md: RTL

EXEC_STAGE_MD -- requirements
Module: exec_stage_md

---
 rtl/exec_stage_md_pkg.sv | 35 +++
 rtl/exec_stage_md_if.sv | 60 ++++++
 rtl/exec_stage_md_muldiv.sv | 98 +++++++++
 rtl/exec_stage_md.sv | 132 +++++++++++++
 4 files changed

// File: rtl/exec_stage_md_pkg.sv
// exec_pkg: opcode, forwarding and FSM encodings shared by the execute stage.
// The iterative multiply/divide path is compiled in when EXEC_MULDIV_EN is defined.
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    localparam logic [1:0] FWD_IDEX  = 2'd0;
    localparam logic [1:0] FWD_WB    = 2'd1;
    localparam logic [1:0] FWD_MEM   = 2'd2;
    localparam logic [1:0] FWD_IDEX3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/exec_stage_md_if.sv
// exec_stage_md_if: ID/EX inputs, forwarding controls and EX/MEM outputs.
// master = pipeline side driving ID/EX, slave = execute stage.
interface exec_stage_md_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             Flush;
    logic [1:0]       FwdRs;
    logic [1:0]       FwdRt;
    logic [WIDTH-1:0] Dst_FeedBack;
    logic             IdEx_RegDst;
    logic             IdEx_Jump;
    logic             IdEx_Branch;
    logic             IdEx_MemRead;
    logic             IdEx_MemtoReg;
    logic             IdEx_MemWrite;
    logic             IdEx_ALU_Src;
    logic             IdEx_RegWrite;
    logic [WIDTH-1:0] IdEx_DataRs;
    logic [WIDTH-1:0] IdEx_DataRt;
    logic [WIDTH-1:0] IdEx_IMM_EX;
    logic [AW-1:0]    IdEx_AddrRt;
    logic [AW-1:0]    IdEx_AddrRd;
    logic [3:0]       CTRL_OP;
    logic             Stall;
    logic             ExMem_Jump;
    logic             ExMem_Branch;
    logic             ExMem_MemRead;
    logic             ExMem_MemtoReg;
    logic             ExMem_MemWrite;
    logic             ExMem_RegWrite;
    logic [WIDTH-1:0] ExMem_AluOut;
    logic [WIDTH-1:0] ExMem_DataRt;
    logic [AW-1:0]    ExMem_AddrRdRt;
    logic             ExMem_ZeroFlag;

    modport master (
        output Flush, FwdRs, FwdRt, Dst_FeedBack,
        output IdEx_RegDst, IdEx_Jump, IdEx_Branch, IdEx_MemRead,
        output IdEx_MemtoReg, IdEx_MemWrite, IdEx_ALU_Src, IdEx_RegWrite,
        output IdEx_DataRs, IdEx_DataRt, IdEx_IMM_EX,
        output IdEx_AddrRt, IdEx_AddrRd, CTRL_OP,
        input  Stall,
        input  ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg,
        input  ExMem_MemWrite, ExMem_RegWrite,
        input  ExMem_AluOut, ExMem_DataRt, ExMem_AddrRdRt, ExMem_ZeroFlag
    );

    modport slave (
        input  Flush, FwdRs, FwdRt, Dst_FeedBack,
        input  IdEx_RegDst, IdEx_Jump, IdEx_Branch, IdEx_MemRead,
        input  IdEx_MemtoReg, IdEx_MemWrite, IdEx_ALU_Src, IdEx_RegWrite,
        input  IdEx_DataRs, IdEx_DataRt, IdEx_IMM_EX,
        input  IdEx_AddrRt, IdEx_AddrRd, CTRL_OP,
        output Stall,
        output ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg,
        output ExMem_MemWrite, ExMem_RegWrite,
        output ExMem_AluOut, ExMem_DataRt, ExMem_AddrRdRt, ExMem_ZeroFlag
    );
endinterface

// File: rtl/exec_stage_md_muldiv.sv
// exec_muldiv: iterative shift-add multiplier and restoring divider, one bit per cycle.
// Only present when EXEC_MULDIV_EN is defined.
`ifdef EXEC_MULDIV_EN
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;
    logic             last;
    logic             is_mul;
    logic             launch;

    // ra holds the shifting dividend/quotient, acc the partial remainder
    assign rem_sh  = {acc_q, ra_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, rb_q};
    assign rem_sub = rem_sh[WIDTH-1:0] - rb_q;
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign is_mul  = op_q == OP_MUL;
    assign launch  = (state_q == IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) state_d = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (abort)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                op_q  <= op;
                ra_q  <= a;
                rb_q  <= b;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == BUSY && !abort) begin
                cnt_q <= cnt_q + 1'b1;
                if (is_mul) begin
                    acc_q <= acc_q + (rb_q[0] ? ra_q : '0);
                    ra_q  <= ra_q << 1;
                    rb_q  <= rb_q >> 1;
                end else begin
                    ra_q  <= {ra_q[WIDTH-2:0], rem_ge};
                    acc_q <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                end
            end
        end
    end

    assign result = (op_q == OP_DIVU) ? ra_q : acc_q;

endmodule
`endif

// File: rtl/exec_stage_md.sv
// exec_stage_md: execute stage with forwarding muxes, ALU and EX/MEM register.
// Define EXEC_MULDIV_EN to add the multi-cycle MUL/DIVU/REMU unit with Stall.
module exec_stage_md
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input logic           CLK,
    input logic           RST,
    exec_stage_md_if.slave bus
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] fwd_rt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res;
    logic [SW-1:0]    shamt;
    logic             stall;

    logic [5:0]       ctl_q;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] rt_q;
    logic [AW-1:0]    dst_q;
    logic             zero_q;

    always_comb begin
        op_a   = bus.IdEx_DataRs;
        fwd_rt = bus.IdEx_DataRt;
        unique case (bus.FwdRs)
            FWD_WB:  op_a = bus.Dst_FeedBack;
            FWD_MEM: op_a = alu_q;
            default: op_a = bus.IdEx_DataRs;
        endcase
        unique case (bus.FwdRt)
            FWD_WB:  fwd_rt = bus.Dst_FeedBack;
            FWD_MEM: fwd_rt = alu_q;
            default: fwd_rt = bus.IdEx_DataRt;
        endcase
        op_b = bus.IdEx_ALU_Src ? bus.IdEx_IMM_EX : fwd_rt;
    end

    assign shamt = op_b[SW-1:0];

    always_comb begin
        alu_res = op_a + op_b;
        unique case (bus.CTRL_OP)
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
            default: alu_res = op_a + op_b;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign md_start = is_muldiv(bus.CTRL_OP);

    exec_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (CLK),
        .rst_n  (RST),
        .start  (md_start),
        .op     (bus.CTRL_OP),
        .a      (op_a),
        .b      (op_b),
        .abort  (bus.Flush),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // stall from the launch cycle through the last BUSY cycle; flush releases it
    assign stall = ~bus.Flush &
                   ((md_start & ~md_busy & ~md_done) | md_busy);
    assign res   = md_done ? md_result : alu_res;
`else
    assign stall = 1'b0;
    assign res   = alu_res;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctl_q  <= '0;
            alu_q  <= '0;
            rt_q   <= '0;
            dst_q  <= '0;
            zero_q <= 1'b0;
        end else if (bus.Flush || stall) begin
            ctl_q <= '0;
        end else begin
            ctl_q  <= {bus.IdEx_Jump, bus.IdEx_Branch,
                       bus.IdEx_MemRead, bus.IdEx_MemtoReg,
                       bus.IdEx_MemWrite, bus.IdEx_RegWrite};
            alu_q  <= res;
            rt_q   <= fwd_rt;
            dst_q  <= bus.IdEx_RegDst ? bus.IdEx_AddrRd
                                      : bus.IdEx_AddrRt;
            zero_q <= res == '0;
        end
    end

    assign bus.Stall          = stall;
    assign bus.ExMem_Jump     = ctl_q[5];
    assign bus.ExMem_Branch   = ctl_q[4];
    assign bus.ExMem_MemRead  = ctl_q[3];
    assign bus.ExMem_MemtoReg = ctl_q[2];
    assign bus.ExMem_MemWrite = ctl_q[1];
    assign bus.ExMem_RegWrite = ctl_q[0];
    assign bus.ExMem_AluOut   = alu_q;
    assign bus.ExMem_DataRt   = rt_q;
    assign bus.ExMem_AddrRdRt = dst_q;
    assign bus.ExMem_ZeroFlag = zero_q;

endmodule
